frame_tx: RTL and testbench
===========================

FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter HEADER, default 8'hCC: frame header byte placed in frame bits [39:32].
REQ-002 Parameter GAP_BITS, default 8: number of idle bit periods inserted after each frame (0 allowed).
REQ-003 clk  input  1  system clock, 500 kHz.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 din  input  24  payload; din[23:16] goes to frame[31:24], din[15:8] to frame[23:16], din[7:0] to frame[15:8].
REQ-006 din_valid  input  1  payload offer.
REQ-007 din_ready  output  1  block can accept a payload this cycle.
REQ-008 bit_en  input  1  one-cycle strobe per transmitted bit period; sync source to the modulator.
REQ-009 ser_o  output  1  serial frame bit.
REQ-010 ser_valid  output  1  ser_o carries a frame bit.
REQ-011 busy  output  1  high in SEND or GAP.
REQ-012 frame_done  output  1  one-cycle pulse on the bit_en that consumes frame bit 39.

Function
REQ-013 The frame SHALL be 40 bits: [39:32]=HEADER, [31:8]=din, [7:0]=checksum.
REQ-014 Checksum SHALL be HEADER + din[23:16] + din[15:8] + din[7:0], truncated modulo 256; no carry retained.
REQ-015 The frame SHALL be sent LSB-first: bit 0 (checksum LSB) first, bit 39 (header MSB) last, so a right-shifting receiver holds the frame aligned after 40 bit_en strobes.
REQ-016 FSM states SHALL be IDLE, SEND and GAP.
REQ-017 IDLE: din_ready=1; a handshake occurs when din_valid&din_ready at a clk edge; the frame is loaded and the state goes to SEND on that edge.
REQ-018 SEND: ser_o=frame[k] and ser_valid=1, with k = bit counter 0..39 starting at 0; ser_o is valid from the first cycle after the handshake.
REQ-019 SEND: each bit_en SHALL advance k by one (shift right); bit_en at k=39 SHALL pulse frame_done in the same cycle and leave SEND at the following edge.
REQ-020 Exit from SEND SHALL go to GAP if GAP_BITS>0, else to IDLE.
REQ-021 GAP: ser_o=0, ser_valid=0; GAP SHALL count GAP_BITS bit_en strobes, then go to IDLE.
REQ-022 din_ready SHALL be 0 in SEND and GAP; din_valid is ignored there, and din need not be held after the handshake.
REQ-023 bit_en in IDLE SHALL be ignored; a handshake and bit_en in the same IDLE cycle SHALL NOT consume a frame bit.
REQ-024 Without bit_en, all outputs and state SHALL hold indefinitely.
REQ-025 In IDLE, ser_o=0 and ser_valid=0.
REQ-026 With GAP_BITS=0, din_ready SHALL assert in the cycle after frame_done, giving back-to-back frames with no idle bit.
REQ-027 All outputs SHALL be registered, except din_ready and frame_done, which are decoded from state and bit_en.

Reset
REQ-028 On rst_n low: state=IDLE, shift register=0, bit and gap counters=0, ser_o=0, ser_valid=0, busy=0, frame_done=0.
REQ-029 Reset during SEND or GAP SHALL abort the frame immediately; no partial frame resumes after release.
REQ-030 din_ready SHALL assert in the first clk cycle after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold FRAME_W=40, PAYLOAD_W=24, default HEADER 8'hCC and the state encoding; the receiving validator uses the same package.
REQ-032 Checksum calculation SHALL be a sub-module frame_checksum (24-bit payload plus header in, 8-bit sum out), reusable by the receiver.
REQ-033 Bit counter SHALL be 6 bits; gap counter width SHALL be $clog2(GAP_BITS+1).

Verification
REQ-034 din=24'h123456, bit_en every 4th cycle -> 40 ser_o bits form 40'hCC12345668 LSB-first; frame_done on 40th strobe.
REQ-035 din=24'hFFFFFF -> checksum 8'hC9 (0x3C9 truncated); frame 40'hCCFFFFFFC9.
REQ-036 Loopback into the receiving validator with sync_flag=bit_en -> valid_flag pulses; valid_data_o=40'hCC12345668.
REQ-037 GAP_BITS=8, din_valid held high -> exactly 8 bit_en strobes with ser_valid=0 between frames; din_ready low throughout.
REQ-038 rst_n pulsed low at bit 20 -> outputs 0 within the reset; the next frame restarts at bit 0 with the correct checksum.
REQ-039 GAP_BITS=0, din_valid held high -> consecutive frames with no bit gap; handshake in the cycle after frame_done.

Source files
------------

// File: rtl/frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx_pkg
// Purpose  : Shared definitions for the serial frame transmitter and the
//            matching receive-side validator: frame geometry, default header
//            byte and the transmitter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package frame_tx_pkg;

  localparam int FRAME_W   = 40;
  localparam int PAYLOAD_W = 24;
  localparam int CSUM_W    = 8;

  localparam logic [7:0] DEFAULT_HEADER = 8'hCC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage : frame_tx_pkg
`default_nettype wire

// File: rtl/frame_checksum.sv
`default_nettype none
// ============================================================================
// Module   : frame_checksum
// Purpose  : Modulo-256 sum of the header byte and the three payload bytes.
//            Purely combinational so the receiver can reuse it to validate
//            an incoming frame.
// Ports    : header  [7:0]   header byte
//            payload [23:0]  payload word
//            sum     [7:0]   truncated byte sum (carries discarded)
// Revision : 1.0 - initial release
// ============================================================================
module frame_checksum
  import frame_tx_pkg::*;
(
  input  logic [7:0]           header,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic [CSUM_W-1:0]    sum
);

  // All operands are 8 bits wide, so the sum wraps naturally at 256.
  assign sum = header + payload[23:16] + payload[15:8] + payload[7:0];

endmodule : frame_checksum
`default_nettype wire

// File: rtl/frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx
// Purpose  : Accepts a 24-bit payload, wraps it into a 40-bit frame
//            {HEADER, payload, checksum} and shifts it out LSB-first, one bit
//            per bit_en strobe, followed by GAP_BITS idle bit periods.
// Ports    : clk         system clock
//            rst_n       asynchronous active-low reset
//            din         payload word
//            din_valid   payload offer
//            din_ready   payload accepted this cycle (IDLE only)
//            bit_en      one strobe per transmitted bit period
//            ser_o       serial frame bit (registered)
//            ser_valid   ser_o carries a frame bit (registered)
//            busy        SEND or GAP in progress (registered)
//            frame_done  strobe that consumes frame bit 39
// Revision : 1.0 - initial release
// ============================================================================
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter logic [7:0] HEADER   = DEFAULT_HEADER,
  parameter int         GAP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 bit_en,
  output logic                 ser_o,
  output logic                 ser_valid,
  output logic                 busy,
  output logic                 frame_done
);

  // A zero-bit counter is not representable, so GAP_BITS=0 keeps one unused bit.
  localparam int                GAP_CW   = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [5:0]        LAST_BIT = 6'(FRAME_W - 1);

  state_t               state,     state_nxt;
  logic [FRAME_W-1:0]   shreg,     shreg_nxt;
  logic [5:0]           bit_cnt,   bit_cnt_nxt;
  logic [GAP_CW-1:0]    gap_cnt,   gap_cnt_nxt;
  logic                 ser_o_nxt;
  logic                 ser_valid_nxt;
  logic                 busy_nxt;
  logic [CSUM_W-1:0]    csum;

  frame_checksum u_checksum (
    .header  (HEADER),
    .payload (din),
    .sum     (csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_o     <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ser_o     <= ser_o_nxt;
      ser_valid <= ser_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    ser_o_nxt     = ser_o;
    ser_valid_nxt = ser_valid;
    busy_nxt      = busy;
    din_ready     = 1'b0;
    frame_done    = 1'b0;

    case (state)
      ST_IDLE: begin
        din_ready = 1'b1;
        // bit_en is deliberately not looked at here: the first frame bit is
        // presented on ser_o before any strobe can consume it.
        if (din_valid) begin
          shreg_nxt     = {HEADER, din, csum};
          bit_cnt_nxt   = '0;
          ser_o_nxt     = csum[0];
          ser_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bit_en) begin
          if (bit_cnt == LAST_BIT) begin
            frame_done    = 1'b1;
            shreg_nxt     = '0;
            bit_cnt_nxt   = '0;
            gap_cnt_nxt   = '0;
            ser_o_nxt     = 1'b0;
            ser_valid_nxt = 1'b0;
            if (GAP_BITS > 0) begin
              state_nxt = ST_GAP;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            // ser_o is registered, so look one bit ahead of the shift.
            shreg_nxt   = shreg >> 1;
            bit_cnt_nxt = bit_cnt + 6'd1;
            ser_o_nxt   = shreg[1];
          end
        end
      end

      ST_GAP: begin
        if (bit_en) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_nxt = '0;
            busy_nxt    = 1'b0;
            state_nxt   = ST_IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt + GAP_CW'(1);
          end
        end
      end

      default: begin
        state_nxt     = ST_IDLE;
        ser_o_nxt     = 1'b0;
        ser_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
      end
    endcase
  end

endmodule : frame_tx
`default_nettype wire

// File: tb/tb_frame_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frame_tx
// Purpose  : Self-checking bench for frame_tx. Two instances: dut_a with an
//            8-bit gap, dut_b with no gap. A queue-based bit-period model
//            predicts every output each cycle; directed frames are captured
//            by a right-shifting receiver and compared with a table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_en;
  logic [23:0] din_a, din_b;
  logic        dv_a, dv_b;
  logic        a_ready, a_ser, a_sv, a_busy, a_done;
  logic        b_ready, b_ser, b_sv, b_busy, b_done;

  int vectors = 0;
  int miscompares = 0;

  always #1000 clk = ~clk;   // 500 kHz

  frame_tx #(.HEADER(8'hCC), .GAP_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(dv_a), .din_ready(a_ready),
    .bit_en(bit_en), .ser_o(a_ser), .ser_valid(a_sv), .busy(a_busy), .frame_done(a_done)
  );

  frame_tx #(.HEADER(8'hCC), .GAP_BITS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(dv_b), .din_ready(b_ready),
    .bit_en(bit_en), .ser_o(b_ser), .ser_valid(b_sv), .busy(b_busy), .frame_done(b_done)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] make_frame(input logic [23:0] d);
    int s;
    s = 8'hCC + d[23:16] + d[15:8] + d[7:0];
    return {8'hCC, d, 8'(s % 256)};
  endfunction

  // ---------------- reference model ----------------
  // One queue entry per pending bit period: {last_frame_bit, valid, bit}.
  // Empty queue means the transmitter is idle.
  typedef logic [2:0] ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  logic [39:0] fa, fb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) qa.delete();
    else if (qa.size() == 0) begin
      if (dv_a) begin
        fa = make_frame(din_a);
        for (int i = 0; i < 40; i++) qa.push_back({i == 39, 1'b1, fa[i]});
        for (int i = 0; i < 8; i++)  qa.push_back(3'b000);
      end
    end else if (bit_en) void'(qa.pop_front());
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) qb.delete();
    else if (qb.size() == 0) begin
      if (dv_b) begin
        fb = make_frame(din_b);
        for (int i = 0; i < 40; i++) qb.push_back({i == 39, 1'b1, fb[i]});
      end
    end else if (bit_en) void'(qb.pop_front());
  end

  // Outputs as {din_ready, ser_o, ser_valid, busy, frame_done}.
  logic [4:0] exp_a, exp_b;
  always @(negedge clk) begin
    #2;
    if (qa.size() == 0) exp_a = 5'b10000;
    else exp_a = {1'b0, qa[0][0], qa[0][1], 1'b1, qa[0][2] & bit_en};
    if (qb.size() == 0) exp_b = 5'b10000;
    else exp_b = {1'b0, qb[0][0], qb[0][1], 1'b1, qb[0][2] & bit_en};
    check("model_a", 40'({a_ready, a_ser, a_sv, a_busy, a_done}), 40'(exp_a));
    check("model_b", 40'({b_ready, b_ser, b_sv, b_busy, b_done}), 40'(exp_b));
  end

  // ---------------- directed helpers ----------------
  task automatic drain;
    int guard = 0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 500) begin
      @(negedge clk); bit_en = 1'b1; guard++;
    end
    @(negedge clk); bit_en = 1'b0;
  endtask

  // Sends one frame on dut_a and captures it with a right-shifting receiver.
  task automatic run_frame_a(input logic [23:0] d, input int period,
                             output logic [39:0] rx, output int done_at);
    int n = 0;
    rx = '0; done_at = 0;
    drain();
    din_a = d; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0; din_a = $urandom;
    for (int cyc = 0; cyc < 40 * period + 20 && done_at == 0; cyc++) begin
      bit_en = ((cyc % period) == period - 1);
      #1;
      if (bit_en && a_sv) begin
        rx = {a_ser, rx[39:1]};
        n++;
        if (a_done) done_at = n;
      end
      @(negedge clk);
    end
    bit_en = 1'b0;
  endtask

  typedef struct {
    logic [23:0] din;
    int          period;
    logic [39:0] frame;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [39:0] rx;
    int          done_at, gap_strobes, n, guard;
    bit          seen;

    tbl[0] = '{24'h123456, 4, 40'hCC12345668};
    tbl[1] = '{24'hFFFFFF, 1, 40'hCCFFFFFFC9};
    tbl[2] = '{24'h000000, 3, 40'hCC000000CC};
    tbl[3] = '{24'h000034, 2, 40'hCC00003400};
    tbl[4] = '{24'hA55A01, 7, 40'hCCA55A01CC};

    rst_n = 1'b0; bit_en = 1'b0; dv_a = 1'b0; dv_b = 1'b0; din_a = '0; din_b = '0;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", 40'({a_ser, a_sv, a_busy, a_done, b_ser, b_sv, b_busy, b_done}), 40'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("ready_after_reset", 40'({a_ready, b_ready}), 40'b11);

    // Table of directed frames
    for (int i = 0; i < 5; i++) begin
      run_frame_a(tbl[i].din, tbl[i].period, rx, done_at);
      check($sformatf("frame_%0d", i), rx, tbl[i].frame);
      check($sformatf("done_pos_%0d", i), 40'(done_at), 40'd40);
    end

    // Gap between frames with din_valid held high
    drain();
    dv_a = 1'b1; din_a = $urandom; seen = 0; gap_strobes = 0; guard = 0;
    while (guard < 400) begin
      @(negedge clk); guard++;
      bit_en = guard[0];
      din_a = $urandom;
      #1;
      if (seen && a_sv) break;
      if (seen && bit_en && a_busy && !a_sv) gap_strobes++;
      if (a_done) seen = 1;
    end
    check("gap_strobes", 40'(gap_strobes), 40'd8);
    @(negedge clk); dv_a = 1'b0; bit_en = 1'b0;

    // Back-to-back frames on the zero-gap instance
    drain();
    dv_b = 1'b1; din_b = 24'h123456; seen = 0; guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk); guard++; bit_en = 1'b1; #1;
      if (b_done) seen = 1;
    end
    check("b_first_done", 40'(seen), 40'd1);
    @(negedge clk); #1;
    check("b_ready_after_done", 40'({b_ready, b_busy, b_sv}), 40'b100);
    @(negedge clk); #1;
    check("b_restart", 40'({b_ready, b_sv, b_busy}), 40'b011);
    @(negedge clk); dv_b = 1'b0; bit_en = 1'b0;

    // Reset in the middle of a frame
    drain();
    din_a = 24'h123456; dv_a = 1'b1;
    @(negedge clk); dv_a = 1'b0; n = 0;
    while (n < 20) begin
      bit_en = 1'b1; #1; if (a_sv) n++;
      @(negedge clk);
    end
    bit_en = 1'b0; rst_n = 1'b0;
    #1 check("mid_reset_outputs", 40'({a_ser, a_sv, a_busy, a_done}), 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_reset_ready", 40'(a_ready), 40'd1);
    run_frame_a(24'h123456, 2, rx, done_at);
    check("post_reset_frame", rx, 40'hCC12345668);
    check("post_reset_done", 40'(done_at), 40'd40);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 499) != 0);
      bit_en = ($urandom_range(0, 2) == 0);
      dv_a   = ($urandom_range(0, 3) != 0);
      dv_b   = ($urandom_range(0, 3) != 0);
      din_a  = $urandom;
      din_b  = $urandom;
    end
    @(negedge clk); rst_n = 1'b1; bit_en = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
    repeat (2) @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_frame_tx
`default_nettype wire
